// File: rtl/bsg_mem_1rw_sync_mask_write_bit_initiator_pkg.sv
// Shared types and helpers for the 1rw mask-write memory initiator.
// Holds the sweep state enum and a safe clog2 used for address widths.
package bsg_mem_1rw_sync_mask_write_bit_initiator_pkg;

  typedef enum logic {
    e_init,
    e_ready
  } init_state_e;

  // A 1-entry memory still needs a 1-bit address.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_initiator_fifo.sv
// Two-entry response buffer for the memory initiator.
// Ports: push_i/data_i enqueue, pop_i dequeues, data_o is the head, count_o the occupancy.
module bsg_mem_1rw_sync_mask_write_bit_initiator_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic [1:0]         count_o
);

  logic [width_p-1:0] mem_r [2];
  logic               wptr_r;
  logic               rptr_r;
  logic [1:0]         count_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_r  <= 1'b0;
      rptr_r  <= 1'b0;
      count_r <= 2'd0;
    end else begin
      if (push_i) wptr_r <= ~wptr_r;
      if (pop_i)  rptr_r <= ~rptr_r;
      count_r <= count_r + 2'(push_i) - 2'(pop_i);
    end
  end

  // Payload needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_r[wptr_r] <= data_i;
  end

  assign data_o  = mem_r[rptr_r];
  assign count_o = count_r;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(push_i && !pop_i && count_r == 2'd2))
        else $error("response buffer overflow");
      assert (!(pop_i && count_r == 2'd0))
        else $error("response buffer underflow");
    end
  end

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_initiator.sv
// Request front end for a 1rw sync mask-write memory: optional zero sweep after reset,
// ready/valid requests in, mem_* port out, 1-cycle read data into a valid/yumi response buffer.
module bsg_mem_1rw_sync_mask_write_bit_initiator
  import bsg_mem_1rw_sync_mask_write_bit_initiator_pkg::*;
#(
  parameter int width_p       = 8,
  parameter int els_p         = 16,
  parameter int init_zero_p   = 1,
  parameter int addr_width_lp = safe_clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [width_p-1:0]       w_mask_i,
  output logic                     ready_o,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i,
  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  output logic [width_p-1:0]       mem_w_mask_o,
  input  logic [width_p-1:0]       mem_data_i
);

  localparam init_state_e reset_state_lp =
    (init_zero_p != 0) ? e_init : e_ready;
  localparam logic [addr_width_lp-1:0] last_addr_lp =
    addr_width_lp'(els_p - 1);

  init_state_e              state_r, state_n;
  logic [addr_width_lp-1:0] cnt_r, cnt_n;
  logic                     pending_r;
  logic                     rd_accept;
  logic [1:0]               count;
  logic [1:0]               credits;
  logic [width_p-1:0]       head;
  logic                     bypass;
  logic                     push;
  logic                     pop;
  logic                     buf_v;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r   <= reset_state_lp;
      cnt_r     <= '0;
      pending_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      pending_r <= rd_accept;
    end
  end

  // Outstanding work: a read in flight in the memory plus buffered data.
  assign credits = count + {1'b0, pending_r};

  always_comb begin
    state_n      = state_r;
    cnt_n        = cnt_r;
    ready_o      = 1'b0;
    mem_v_o      = 1'b0;
    mem_w_o      = w_i;
    mem_addr_o   = addr_i;
    mem_data_o   = data_i;
    mem_w_mask_o = w_mask_i;
    unique case (state_r)
      e_init: begin
        mem_v_o      = ~reset_i;
        mem_w_o      = 1'b1;
        mem_addr_o   = cnt_r;
        mem_data_o   = '0;
        mem_w_mask_o = '1;
        if (cnt_r == last_addr_lp) begin
          state_n = e_ready;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_r + addr_width_lp'(1);
        end
      end
      e_ready: begin
        // Depends only on local state so no comb path from v_i/yumi_i.
        ready_o = ~reset_i & (credits < 2'd2);
        mem_v_o = v_i & ready_o;
      end
      default: ;
    endcase
  end

  assign rd_accept = (state_r == e_ready) & v_i & ready_o & ~w_i;

  // Memory data is only valid for one cycle; park it unless taken now.
  assign buf_v  = (count != 2'd0);
  assign bypass = pending_r & ~buf_v & yumi_i;
  assign push   = pending_r & ~bypass;
  assign pop    = yumi_i & buf_v;

  bsg_mem_1rw_sync_mask_write_bit_initiator_fifo #(
    .width_p (width_p)
  ) rsp_buf (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push),
    .data_i  (mem_data_i),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count)
  );

  assign v_o    = buf_v | pending_r;
  assign data_o = buf_v ? head : mem_data_i;

  logic [31:0] addr_ext;
  assign addr_ext = 32'(addr_i);

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !v_o))
        else $error("yumi_i asserted without v_o");
      if (v_i && ready_o) begin
        assert (addr_ext < 32'(els_p))
          else $error("request address out of range");
      end
    end
  end

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_bit_initiator.sv
// Directed bench for the 1rw mask-write initiator with behavioural memories.
// Covers zero sweep, masked writes, streaming, backpressure, resets, no-sweep build.
module tb_bsg_mem_1rw_sync_mask_write_bit_initiator;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, v, w, yumi;
  logic [3:0] addr;
  logic [7:0] din, mask;
  logic       ready, vo, mv, mw;
  logic [7:0] dout, mdata, mmask, mrd;
  logic [3:0] maddr;

  logic       rst0, v0, w0, yumi0;
  logic [3:0] addr0;
  logic [7:0] din0, mask0;
  logic       ready0, vo0, mv0, mw0;
  logic [7:0] dout0, mdata0, mmask0, mrd0;
  logic [3:0] maddr0;

  int checks = 0;
  int errors = 0;

  bsg_mem_1rw_sync_mask_write_bit_initiator #(
    .width_p(8), .els_p(16), .init_zero_p(1)
  ) dut (
    .clk_i(clk), .reset_i(rst), .v_i(v), .w_i(w), .addr_i(addr),
    .data_i(din), .w_mask_i(mask), .ready_o(ready), .v_o(vo),
    .data_o(dout), .yumi_i(yumi), .mem_v_o(mv), .mem_w_o(mw),
    .mem_addr_o(maddr), .mem_data_o(mdata), .mem_w_mask_o(mmask),
    .mem_data_i(mrd)
  );

  bsg_mem_1rw_sync_mask_write_bit_initiator #(
    .width_p(8), .els_p(16), .init_zero_p(0)
  ) dut0 (
    .clk_i(clk), .reset_i(rst0), .v_i(v0), .w_i(w0), .addr_i(addr0),
    .data_i(din0), .w_mask_i(mask0), .ready_o(ready0), .v_o(vo0),
    .data_o(dout0), .yumi_i(yumi0), .mem_v_o(mv0), .mem_w_o(mw0),
    .mem_addr_o(maddr0), .mem_data_o(mdata0), .mem_w_mask_o(mmask0),
    .mem_data_i(mrd0)
  );

  logic [7:0] mem  [16];
  logic [7:0] mem0 [16];

  always @(posedge clk) begin
    if (mv) begin
      if (mw) mem[maddr] <= (mem[maddr] & ~mmask) | (mdata & mmask);
      else    mrd <= mem[maddr];
    end
    if (mv0) begin
      if (mw0) mem0[maddr0] <= (mem0[maddr0] & ~mmask0) | (mdata0 & mmask0);
      else     mrd0 <= mem0[maddr0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Call just after reset release at a negedge; walks the 16-cycle sweep.
  task automatic sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      #1;
      chk({tag, "_sweep"}, {mv, mw, maddr, mdata, mmask, ready},
          {1'b1, 1'b1, 4'(i), 8'h00, 8'hFF, 1'b0});
      @(negedge clk);
    end
    #1;
    chk({tag, "_ready"}, {ready, mv}, 2'b10);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d,
                    input logic [7:0] m);
    @(negedge clk);
    v = 1; w = 1; addr = a; din = d; mask = m; yumi = 0;
    #1;
    chk("wr_issue", {ready, mv, mw, maddr, mdata, mmask},
        {1'b1, 1'b1, 1'b1, a, d, m});
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a,
                          input logic [7:0] exp);
    @(negedge clk);
    v = 1; w = 0; addr = a; yumi = 0;
    #1;
    chk({tag, "_req"}, {ready, mv, mw, vo}, 4'b1100);
    @(negedge clk);
    v = 0; yumi = 1;
    #1;
    chk({tag, "_rsp"}, {vo, dout}, {1'b1, exp});
    @(negedge clk);
    yumi = 0;
    #1;
    chk({tag, "_idle"}, vo, 0);
  endtask

  initial begin
    rst = 1; v = 0; w = 0; addr = 0; din = 0; mask = 0; yumi = 0;
    rst0 = 1; v0 = 0; w0 = 0; addr0 = 0; din0 = 0; mask0 = 0; yumi0 = 0;
    #2;
    chk("rst_out", {ready, vo, mv}, 3'b000);
    chk("rst_out0", {ready0, vo0, mv0}, 3'b000);

    @(negedge clk);
    rst = 0; rst0 = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("init_sweep", {mv, mw, maddr, mdata, mmask, ready},
          {1'b1, 1'b1, 4'(i), 8'h00, 8'hFF, 1'b0});
      chk("noinit_quiet", {ready0, mv0, vo0}, 3'b100);
      @(negedge clk);
    end
    #1;
    chk("init_done", {ready, mv}, 2'b10);

    rd_check("zero_a9", 4'd9, 8'h00);

    // Build without sweep: plain write then read round trip.
    @(negedge clk);
    v0 = 1; w0 = 1; addr0 = 2; din0 = 8'h5A; mask0 = 8'hFF;
    #1;
    chk("n0_wr", {ready0, mv0, mw0, maddr0}, {1'b1, 1'b1, 1'b1, 4'd2});
    @(negedge clk);
    w0 = 0;
    #1;
    chk("n0_rd", {ready0, mv0, mw0}, 3'b110);
    @(negedge clk);
    v0 = 0;
    #1;
    chk("n0_rsp", {vo0, dout0}, {1'b1, 8'h5A});
    yumi0 = 1;
    @(negedge clk);
    yumi0 = 0;
    #1;
    chk("n0_idle", {vo0, mv0}, 2'b00);

    wr(4'd3, 8'hA5, 8'h0F);
    rd_check("mask_lo", 4'd3, 8'h05);
    wr(4'd3, 8'h3C, 8'hF0);
    rd_check("mask_hi", 4'd3, 8'h35);

    for (int k = 0; k < 8; k++) wr(4'(k), 8'h10 + 8'(k), 8'hFF);

    // Streaming reads, one per cycle.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      v = 1; w = 0; addr = 4'(k); yumi = (k > 0);
      #1;
      chk("stream_rdy", {ready, mv}, 2'b11);
      if (k > 0) chk("stream_rsp", {vo, dout}, {1'b1, 8'h10 + 8'(k - 1)});
    end
    @(negedge clk);
    v = 0; yumi = 1;
    #1;
    chk("stream_last", {vo, dout}, {1'b1, 8'h17});
    @(negedge clk);
    yumi = 0;
    #1;
    chk("stream_idle", vo, 0);

    // Backpressure: reads 1,2,3 with no yumi.
    @(negedge clk);
    v = 1; w = 0; addr = 1; yumi = 0;
    #1;
    chk("bp_a", {ready, vo}, 2'b10);
    @(negedge clk);
    addr = 2;
    #1;
    chk("bp_b", {ready, vo, dout}, {1'b1, 1'b1, 8'h11});
    @(negedge clk);
    addr = 3;
    #1;
    chk("bp_c", {ready, mv, vo, dout}, {1'b0, 1'b0, 1'b1, 8'h11});
    @(negedge clk);
    yumi = 1;
    #1;
    chk("bp_d", {ready, vo, dout}, {1'b0, 1'b1, 8'h11});
    @(negedge clk);
    #1;
    chk("bp_e", {ready, mv, vo, dout}, {1'b1, 1'b1, 1'b1, 8'h12});
    @(negedge clk);
    v = 0;
    #1;
    chk("bp_f", {vo, dout}, {1'b1, 8'h13});
    @(negedge clk);
    yumi = 0;
    #1;
    chk("bp_g", vo, 0);

    // Push and pop together keep the occupancy at one.
    @(negedge clk);
    v = 1; w = 0; addr = 4; yumi = 0;
    @(negedge clk);
    addr = 6;
    @(negedge clk);
    v = 0; yumi = 1;
    #1;
    chk("pp_a", {vo, dout}, {1'b1, 8'h14});
    @(negedge clk);
    #1;
    chk("pp_b", {vo, dout, ready}, {1'b1, 8'h16, 1'b1});
    @(negedge clk);
    yumi = 0;
    #1;
    chk("pp_c", vo, 0);

    // Write right after a read to the same address.
    @(negedge clk);
    v = 1; w = 0; addr = 5; yumi = 0;
    @(negedge clk);
    w = 1; din = 8'h99; mask = 8'hFF; yumi = 1;
    #1;
    chk("war_rsp", {vo, dout, mv, mw}, {1'b1, 8'h15, 1'b1, 1'b1});
    @(negedge clk);
    v = 0; yumi = 0;
    #1;
    chk("war_idle", vo, 0);
    rd_check("war_new", 4'd5, 8'h99);

    // Async reset in the middle of the sweep.
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 7; i++) @(negedge clk);
    #1;
    chk("mid_a7", {mv, maddr}, {1'b1, 4'd7});
    #2 rst = 1;
    #1;
    chk("mid_drop", {mv, ready}, 2'b00);
    @(negedge clk);
    rst = 0;
    sweep("mid");

    // Async reset with a buffered response.
    @(negedge clk);
    v = 1; w = 0; addr = 9; yumi = 0;
    @(negedge clk);
    v = 0;
    @(negedge clk);
    #1;
    chk("rb_held", {vo, dout}, {1'b1, 8'h00});
    #2 rst = 1;
    #1;
    chk("rb_drop", {vo, mv, ready}, 3'b000);
    @(negedge clk);
    rst = 0;
    sweep("rb");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
